// File: rtl/key_matrix_scanner_pkg.sv
// Shared constants and types for the key matrix scanner and its event buffer.
package key_matrix_scanner_pkg;

    localparam int KEY_W      = 5;   // key index width (col*8 + row)
    localparam int N_ROWS     = 8;   // row sense lines
    localparam int N_COLS     = 4;   // column strobes
    localparam int N_KEYS     = N_ROWS * N_COLS;
    localparam int FIFO_DEPTH = 4;   // event buffer entries
    localparam int ROW_W      = 3;   // row index width
    localparam int COL_W      = 2;   // column index width
    localparam int CNT_W      = 3;   // per-key mismatch counter width

    // One key event: which key changed and its new state.
    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic             press;
    } evt_t;

    // Active-low one-cold strobe pattern for a column index.
    function automatic logic [N_COLS-1:0] col_strobe_n(input logic [COL_W-1:0] col);
        col_strobe_n = ~(N_COLS'(1) << col);
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small event buffer: FIFO_DEPTH entries of evt_t, valid/ready read side.
// A push while full is accepted only if the head is popped in the same cycle;
// otherwise the event is dropped and o_drop pulses for that cycle.
module key_event_fifo
    import key_matrix_scanner_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  evt_t i_data,
    output logic o_valid,
    input  logic i_ready,
    output evt_t o_data,
    output logic o_full,
    output logic o_drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    evt_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_pop;
    logic w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = o_valid & i_ready;
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & o_full & ~w_pop;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// 4x8 key matrix scanner: strobes one column at a time, samples the rows at the
// end of each column dwell, debounces each key with a mismatch counter and
// queues press/release events in a small FIFO.
module key_matrix_scanner
    import key_matrix_scanner_pkg::*;
#(
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              CLK,
    input  logic              RST,
    output logic [N_COLS-1:0] COL_N,
    input  logic [N_ROWS-1:0] ROW_N,
    output logic [N_KEYS-1:0] KEYS,
    output logic              EVT_VALID,
    input  logic              EVT_READY,
    output logic [KEY_W-1:0]  EVT_KEY,
    output logic              EVT_PRESS,
    output logic              OVERFLOW
);

    localparam int               DIV_W     = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W:0]   DEB_LIMIT = (CNT_W+1)'(DEBOUNCE_SCANS);

    // Scan timing
    logic [DIV_W-1:0]  r_dwell;
    logic [COL_W-1:0]  r_col;
    // Row synchronizer
    logic [N_ROWS-1:0] r_sync1;
    logic [N_ROWS-1:0] r_sync2;
    // Captured sample and row sequencer
    logic [N_ROWS-1:0] r_sample;
    logic [COL_W-1:0]  r_sample_col;
    logic              r_proc_active;
    logic [ROW_W-1:0]  r_proc_row;
    // Debounced state
    logic [N_KEYS-1:0] r_keys;
    logic [CNT_W-1:0]  r_mis [N_KEYS];
    logic              r_overflow;

    logic              w_capture;
    logic [KEY_W-1:0]  w_key;
    logic              w_sample_bit;
    logic              w_key_bit;
    logic [CNT_W-1:0]  w_mis_cur;
    logic [CNT_W:0]    w_mis_inc;
    logic              w_match;
    logic              w_toggle;
    evt_t              w_evt;
    evt_t              w_head;
    logic              w_full;
    logic              w_drop;

    assign w_capture    = (r_dwell == DIV_LAST);
    assign w_key        = {r_sample_col, r_proc_row};
    assign w_sample_bit = r_sample[r_proc_row];
    assign w_key_bit    = r_keys[w_key];
    assign w_mis_cur    = r_mis[w_key];
    assign w_mis_inc    = {1'b0, w_mis_cur} + (CNT_W+1)'(1);
    assign w_match      = (w_sample_bit == w_key_bit);
    assign w_toggle     = r_proc_active & ~w_match & (w_mis_inc == DEB_LIMIT);
    assign w_evt        = '{key: w_key, press: ~w_key_bit};

    // Column dwell counter and active column; the column advances on wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dwell <= '0;
            r_col   <= '0;
        end else if (w_capture) begin
            r_dwell <= '0;
            r_col   <= r_col + COL_W'(1);
        end else begin
            r_dwell <= r_dwell + DIV_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous row lines (idle = released = 1).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= ROW_N;
            r_sync2 <= r_sync1;
        end
    end

    // Capture the pressed pattern at end of dwell, then walk rows 0..7 one per cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sample      <= '0;
            r_sample_col  <= '0;
            r_proc_active <= 1'b0;
            r_proc_row    <= '0;
        end else if (w_capture) begin
            r_sample      <= ~r_sync2;
            r_sample_col  <= r_col;
            r_proc_active <= 1'b1;
            r_proc_row    <= '0;
        end else if (r_proc_active) begin
            if (r_proc_row == ROW_W'(N_ROWS - 1)) begin
                r_proc_active <= 1'b0;
            end
            r_proc_row <= r_proc_row + ROW_W'(1);
        end
    end

    // Per-key debounce: count disagreeing samples, flip the key when the limit is hit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_keys <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_mis[i] <= '0;
            end
        end else if (r_proc_active) begin
            if (w_match) begin
                r_mis[w_key] <= '0;
            end else if (w_toggle) begin
                r_keys[w_key] <= ~w_key_bit;
                r_mis[w_key]  <= '0;
            end else begin
                r_mis[w_key] <= w_mis_inc[CNT_W-1:0];
            end
        end
    end

    // Sticky overflow flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    key_event_fifo u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_toggle),
        .i_data  (w_evt),
        .o_valid (EVT_VALID),
        .i_ready (EVT_READY),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_drop  (w_drop)
    );

    assign COL_N     = col_strobe_n(r_col);
    assign KEYS      = r_keys;
    assign EVT_KEY   = w_head.key;
    assign EVT_PRESS = w_head.press;
    assign OVERFLOW  = r_overflow;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner with a keypad model and an event scoreboard.
// Event handshake: an event transfers on a rising edge where EVT_VALID and
// EVT_READY are both 1; while EVT_VALID=1 and EVT_READY=0 the head must hold.
module tb_key_matrix_scanner;

    logic        CLK;
    logic        RST;
    logic [3:0]  COL_N;
    logic [7:0]  row_n;
    logic [31:0] KEYS;
    logic        EVT_VALID;
    logic        EVT_READY;
    logic [4:0]  EVT_KEY;
    logic        EVT_PRESS;
    logic        OVERFLOW;

    logic [31:0] tb_pressed;
    logic [5:0]  exp_q[$];
    int          n_tests;
    int          n_fail;
    int          ev_count;
    logic        stall_prev;
    logic [5:0]  head_prev;

    key_matrix_scanner #(.SCAN_DIV(16), .DEBOUNCE_SCANS(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .COL_N     (COL_N),
        .ROW_N     (row_n),
        .KEYS      (KEYS),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_KEY   (EVT_KEY),
        .EVT_PRESS (EVT_PRESS),
        .OVERFLOW  (OVERFLOW)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- keypad model ----------------
    always_comb begin
        row_n = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (tb_pressed[c*8+r] && !COL_N[c]) row_n[r] = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Returns #1 after the first edge at which COL_N changes into pat.
    task automatic wait_col_enter(input logic [3:0] pat, input string tag);
        logic [3:0] prev;
        bit         hit;
        prev = COL_N;
        hit  = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge CLK);
            #1;
            if (COL_N == pat && prev != pat) hit = 1;
            prev = COL_N;
        end
        if (!hit) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for COL_N=%b, got %b", tag, pat, COL_N);
        end
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        tick(3);
        RST = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        logic [5:0] exp_ev;
        if (!RST) begin
            if (stall_prev && EVT_VALID) begin
                n_tests++;
                if ({EVT_KEY, EVT_PRESS} !== head_prev) begin
                    n_fail++;
                    $display("FAIL head_stable: got %h expected %h", {EVT_KEY, EVT_PRESS}, head_prev);
                end
            end
            if (EVT_VALID && EVT_READY) begin
                n_tests++;
                ev_count++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got key %0d press %0d, expected none", EVT_KEY, EVT_PRESS);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if ({EVT_KEY, EVT_PRESS} !== exp_ev) begin
                        n_fail++;
                        $display("FAIL event: got key %0d press %0d, expected key %0d press %0d",
                                 EVT_KEY, EVT_PRESS, exp_ev[5:1], exp_ev[0]);
                    end
                end
            end
            stall_prev = EVT_VALID && !EVT_READY;
            head_prev  = {EVT_KEY, EVT_PRESS};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ev_base;
        n_tests    = 0;
        n_fail     = 0;
        ev_count   = 0;
        stall_prev = 1'b0;
        head_prev  = '0;
        RST        = 1'b1;
        EVT_READY  = 1'b0;
        tb_pressed = '0;

        // T1: reset values and first column advance
        @(posedge CLK);
        #1 RST = 1'b1;
        tick(3);
        check("rst_col_n",     {28'd0, COL_N}, 32'h0000_000E);
        check("rst_keys",      KEYS, 32'h0);
        check("rst_evt_valid", {31'd0, EVT_VALID}, 32'h0);
        check("rst_overflow",  {31'd0, OVERFLOW}, 32'h0);
        RST = 1'b0;
        tick(15);
        check("col0_hold_15", {28'd0, COL_N}, 32'h0000_000E);
        tick(1);
        check("col1_at_16", {28'd0, COL_N}, 32'h0000_000D);

        // T2: press and release key (2,3) = 19 with consumer ready
        EVT_READY = 1'b1;
        ev_base = ev_count;
        exp_q.push_back({5'd19, 1'b1});
        tb_pressed[19] = 1'b1;
        tick(320);
        check("t2_keys_press", KEYS, 32'h0008_0000);
        check("t2_press_events", ev_count - ev_base, 1);
        exp_q.push_back({5'd19, 1'b0});
        tb_pressed[19] = 1'b0;
        tick(320);
        check("t2_keys_release", KEYS, 32'h0);
        check("t2_total_events", ev_count - ev_base, 2);
        check("t2_queue_empty", exp_q.size(), 0);

        // T3: key (0,0) held for only 3 scans -> filtered out
        ev_base = ev_count;
        wait_col_enter(4'b1110, "t3_sync");
        tb_pressed[0] = 1'b1;
        tick(192);
        tb_pressed[0] = 1'b0;
        tick(128);
        check("t3_keys", KEYS, 32'h0);
        check("t3_no_event", ev_count - ev_base, 0);

        // T4: five simultaneous presses with consumer stalled -> overflow
        EVT_READY = 1'b0;
        for (int k = 8; k <= 11; k++) exp_q.push_back({5'(k), 1'b1});
        tb_pressed[12:8] = 5'h1F;
        tick(320);
        check("t4_keys", KEYS, 32'h0000_1F00);
        check("t4_overflow", {31'd0, OVERFLOW}, 32'h1);
        check("t4_valid", {31'd0, EVT_VALID}, 32'h1);
        check("t4_head_key", {27'd0, EVT_KEY}, 32'd8);
        ev_base = ev_count;
        EVT_READY = 1'b1;
        tick(20);
        check("t4_drained", ev_count - ev_base, 4);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_overflow_sticky", {31'd0, OVERFLOW}, 32'h1);
        check("t4_valid_after", {31'd0, EVT_VALID}, 32'h0);

        // T5: full FIFO, pop in the same cycle as a new push -> no overflow
        tb_pressed = '0;
        pulse_reset();
        check("t5_overflow_cleared", {31'd0, OVERFLOW}, 32'h0);
        EVT_READY = 1'b0;
        for (int k = 8; k <= 11; k++) exp_q.push_back({5'(k), 1'b1});
        tb_pressed[11:8] = 4'hF;
        tick(320);
        check("t5_full_no_ovf", {31'd0, OVERFLOW}, 32'h0);
        wait_col_enter(4'b1011, "t5_sync");
        tb_pressed[16] = 1'b1;
        exp_q.push_back({5'd16, 1'b1});
        for (int s = 0; s < 4; s++) wait_col_enter(4'b0111, "t5_scan");
        // row 0 of the 4th column-2 sample is pushed at the end of this cycle
        EVT_READY = 1'b1;
        tick(1);
        EVT_READY = 1'b0;
        tick(1);
        check("t5_overflow", {31'd0, OVERFLOW}, 32'h0);
        check("t5_keys", KEYS, 32'h0001_0F00);
        check("t5_head_key", {27'd0, EVT_KEY}, 32'd9);
        ev_base = ev_count;
        EVT_READY = 1'b1;
        tick(20);
        check("t5_remaining", ev_count - ev_base, 4);
        check("t5_queue_empty", exp_q.size(), 0);

        // T6: reset at capture+3 of a debounce-completing sample for key (2,5) = 21
        tb_pressed = '0;
        pulse_reset();
        EVT_READY = 1'b1;
        ev_base = ev_count;
        wait_col_enter(4'b1011, "t6_sync");
        tb_pressed[21] = 1'b1;
        for (int s = 0; s < 4; s++) wait_col_enter(4'b0111, "t6_scan");
        tick(2);
        check("t6_keys_before_rst", KEYS, 32'h0);
        RST = 1'b1;
        tb_pressed = '0;
        tick(3);
        check("t6_rst_col_n", {28'd0, COL_N}, 32'h0000_000E);
        check("t6_rst_valid", {31'd0, EVT_VALID}, 32'h0);
        RST = 1'b0;
        tick(192);
        check("t6_keys_after", KEYS, 32'h0);
        check("t6_no_event", ev_count - ev_base, 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
